// File: rtl/fpm_pkg.sv
// Shared definitions for the floating-point arithmetic pipelines:
// operand classes, flag positions and format helper functions.
package fpm_pkg;

   typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fpm_cls_e;

   localparam int FLAG_OVF  = 0;
   localparam int FLAG_UNF  = 1;
   localparam int FLAG_INV  = 2;
   localparam int NUM_FLAGS = 3;

   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Canonical quiet NaN, built wide; callers truncate to their operand width.
   function automatic logic [127:0] qnan(input int ew, input int mw);
      logic [127:0] r;
      r = ((128'd1 << ew) - 128'd1) << mw;
      r = r | (128'd1 << (mw - 1));
      return r;
   endfunction

endpackage

// File: rtl/fpm_norm_round.sv
// Normalise, round and pack a raw mantissa product with special-case override.
// Build option FPM_PIPE_RNE_EN selects round-to-nearest-even; default truncates.
module fpm_norm_round
   import fpm_pkg::*;
#(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic                  sign,
   input  fpm_cls_e              cls_a,
   input  fpm_cls_e              cls_b,
   input  logic signed [EW+1:0]  exp_in,
   input  logic [2*MW+1:0]       prod,
   output logic [EW+MW:0]        res,
   output logic [NUM_FLAGS-1:0]  flags
);

   localparam int PW = 2 * MW + 2;
   localparam logic [EW+MW:0]       QNAN  = (EW + MW + 1)'(qnan(EW, MW));
   localparam logic signed [EW+1:0] EMAX  = {2'b00, {EW{1'b1}}};
   localparam logic signed [EW+1:0] EZERO = '0;
`ifdef FPM_PIPE_RNE_EN
   localparam logic RNE_EN = 1'b1;
`else
   localparam logic RNE_EN = 1'b0;
`endif

   logic [PW-2:0]        norm;
   logic [MW-1:0]        frac;
   logic                 guard, sticky, inc;
   logic [MW:0]          frac_r;
   logic signed [EW+1:0] exp_f;
   logic                 nan_any, inf_any, zero_any;

   always_comb begin
      // Hidden bit dropped: it sits at PW-1 or PW-2 depending on the product range.
      norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      frac     = norm[PW-2 -: MW];
      guard    = norm[PW-2-MW];
      sticky   = |norm[PW-3-MW:0];
      inc      = RNE_EN & guard & (sticky | frac[0]);
      frac_r   = {1'b0, frac} + {{MW{1'b0}}, inc};
      exp_f    = exp_in + {{(EW+1){1'b0}}, prod[PW-1]} + {{(EW+1){1'b0}}, frac_r[MW]};

      nan_any  = (cls_a == NAN)  || (cls_b == NAN);
      inf_any  = (cls_a == INF)  || (cls_b == INF);
      zero_any = (cls_a == ZERO) || (cls_b == ZERO);

      res   = {sign, exp_f[EW-1:0], frac_r[MW-1:0]};
      flags = '0;
      if (nan_any || (inf_any && zero_any)) begin
         res             = QNAN;
         flags[FLAG_INV] = 1'b1;
      end else if (inf_any) begin
         res = {sign, {EW{1'b1}}, {MW{1'b0}}};
      end else if (zero_any) begin
         res = {sign, {(EW+MW){1'b0}}};
      end else if (exp_f >= EMAX) begin
         res             = {sign, {EW{1'b1}}, {MW{1'b0}}};
         flags[FLAG_OVF] = 1'b1;
      end else if (exp_f <= EZERO) begin
         res             = {sign, {(EW+MW){1'b0}}};
         flags[FLAG_UNF] = 1'b1;
      end
   end

endmodule

// File: rtl/fpm_pipe.sv
// Three-stage pipelined FP multiplier: classify/exponent, multiply, normalise/pack.
// Rounding mode chosen at build time by FPM_PIPE_RNE_EN (see fpm_norm_round).
module fpm_pipe
   import fpm_pkg::*;
#(
   parameter int EW = 8,
   parameter int MW = 23,
   parameter int W  = 1 + EW + MW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic         flag_ovf,
   output logic         flag_unf,
   output logic         flag_inv
);

   localparam int XW = EW + 2;
   localparam int PW = 2 * MW + 2;
   localparam logic signed [XW-1:0] BIAS = XW'(bias(EW));

   logic                 advance;
   logic [2:0]           vld_q, vld_d;
   logic                 s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d;
   fpm_cls_e             s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
   fpm_cls_e             s2_cls_a_q, s2_cls_a_d, s2_cls_b_q, s2_cls_b_d;
   logic signed [XW-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
   logic [MW-1:0]        s1_fa_q, s1_fa_d, s1_fb_q, s1_fb_d;
   logic [PW-1:0]        s2_prod_q, s2_prod_d;
   logic [W-1:0]         product_q, product_d, nr_res;
   logic [NUM_FLAGS-1:0] flags_q, flags_d, nr_flags;

   function automatic fpm_cls_e classify(input logic [EW-1:0] e, input logic [MW-1:0] f);
      if (e == '0) return ZERO;
      if (e == '1) return (f == '0) ? INF : NAN;
      return NORMAL;
   endfunction

   always_comb begin
      advance    = !vld_q[2] || out_ready;
      vld_d      = vld_q;
      s1_sign_d  = s1_sign_q;
      s1_cls_a_d = s1_cls_a_q;
      s1_cls_b_d = s1_cls_b_q;
      s1_exp_d   = s1_exp_q;
      s1_fa_d    = s1_fa_q;
      s1_fb_d    = s1_fb_q;
      s2_sign_d  = s2_sign_q;
      s2_cls_a_d = s2_cls_a_q;
      s2_cls_b_d = s2_cls_b_q;
      s2_exp_d   = s2_exp_q;
      s2_prod_d  = s2_prod_q;
      product_d  = product_q;
      flags_d    = flags_q;
      // Whole pipe moves in lockstep; a stall freezes every stage including the output.
      if (advance) begin
         vld_d      = {vld_q[1:0], in_valid};
         s1_sign_d  = a[W-1] ^ b[W-1];
         s1_cls_a_d = classify(a[W-2 -: EW], a[MW-1:0]);
         s1_cls_b_d = classify(b[W-2 -: EW], b[MW-1:0]);
         s1_exp_d   = $signed({2'b00, a[W-2 -: EW]}) + $signed({2'b00, b[W-2 -: EW]}) - BIAS;
         s1_fa_d    = a[MW-1:0];
         s1_fb_d    = b[MW-1:0];
         s2_sign_d  = s1_sign_q;
         s2_cls_a_d = s1_cls_a_q;
         s2_cls_b_d = s1_cls_b_q;
         s2_exp_d   = s1_exp_q;
         s2_prod_d  = {{(MW+1){1'b0}}, 1'b1, s1_fa_q} * {{(MW+1){1'b0}}, 1'b1, s1_fb_q};
         product_d  = vld_q[1] ? nr_res   : '0;
         flags_d    = vld_q[1] ? nr_flags : '0;
      end
   end

   fpm_norm_round #(.EW(EW), .MW(MW)) u_norm_round (
      .sign   (s2_sign_q),
      .cls_a  (s2_cls_a_q),
      .cls_b  (s2_cls_b_q),
      .exp_in (s2_exp_q),
      .prod   (s2_prod_q),
      .res    (nr_res),
      .flags  (nr_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         s1_sign_q  <= 1'b0;
         s1_cls_a_q <= ZERO;
         s1_cls_b_q <= ZERO;
         s1_exp_q   <= '0;
         s1_fa_q    <= '0;
         s1_fb_q    <= '0;
         s2_sign_q  <= 1'b0;
         s2_cls_a_q <= ZERO;
         s2_cls_b_q <= ZERO;
         s2_exp_q   <= '0;
         s2_prod_q  <= '0;
         product_q  <= '0;
         flags_q    <= '0;
      end else begin
         vld_q      <= vld_d;
         s1_sign_q  <= s1_sign_d;
         s1_cls_a_q <= s1_cls_a_d;
         s1_cls_b_q <= s1_cls_b_d;
         s1_exp_q   <= s1_exp_d;
         s1_fa_q    <= s1_fa_d;
         s1_fb_q    <= s1_fb_d;
         s2_sign_q  <= s2_sign_d;
         s2_cls_a_q <= s2_cls_a_d;
         s2_cls_b_q <= s2_cls_b_d;
         s2_exp_q   <= s2_exp_d;
         s2_prod_q  <= s2_prod_d;
         product_q  <= product_d;
         flags_q    <= flags_d;
      end
   end

   assign in_ready  = advance;
   assign out_valid = vld_q[2];
   assign product   = product_q;
   assign flag_ovf  = flags_q[FLAG_OVF];
   assign flag_unf  = flags_q[FLAG_UNF];
   assign flag_inv  = flags_q[FLAG_INV];

endmodule

// File: tb/tb_fpm_pipe.sv
// Self-checking bench for fpm_pipe: directed vectors through a scoreboard queue.
module tb_fpm_pipe;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, product;
   logic        flag_ovf, flag_unf, flag_inv;

   typedef struct packed {
      logic [31:0] p;
      logic [2:0]  f;   // {inv, unf, ovf}
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] va [0:15];
   logic [31:0] vb [0:15];
   logic [31:0] vp [0:15];
   logic [2:0]  vf [0:15];
   int          n_chk = 0;
   int          n_pass = 0;

   fpm_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] p, input logic [2:0] f);
      va[i] = x; vb[i] = y; vp[i] = p; vf[i] = f;
   endtask

   task automatic init_vectors();
      set_vec(0,  32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
      set_vec(1,  32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
`ifdef FPM_PIPE_RNE_EN
      set_vec(2,  32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000);
`else
      set_vec(2,  32'h3FC00000, 32'h3F800001, 32'h3FC00001, 3'b000);
`endif
      set_vec(3,  32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
      set_vec(4,  32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
      set_vec(5,  32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b001);
      set_vec(6,  32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
      set_vec(7,  32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
      set_vec(8,  32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100);
      set_vec(9,  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
      set_vec(10, 32'h00000001, 32'h40000000, 32'h00000000, 3'b000);
      set_vec(11, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
      set_vec(12, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
      set_vec(13, 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
      set_vec(14, 32'h40800000, 32'h3F000000, 32'h40000000, 3'b000);
      set_vec(15, 32'h3F800000, 32'hBF800000, 32'hBF800000, 3'b000);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
      n_chk++; if (product !== 32'h0) $display("FAIL reset_product got=%h want=0", product); else n_pass++;
      n_chk++; if ({flag_inv, flag_unf, flag_ovf} !== 3'b000)
         $display("FAIL reset_flags got=%b want=000", {flag_inv, flag_unf, flag_ovf}); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_latency();
      int lat;
      a = va[0]; b = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      n_chk++; if (lat !== 3) $display("FAIL latency got=%0d want=3", lat); else n_pass++;
      n_chk++; if (product !== vp[0]) $display("FAIL basic_product got=%h want=%h", product, vp[0]); else n_pass++;
      n_chk++; if ({flag_inv, flag_unf, flag_ovf} !== 3'b000)
         $display("FAIL basic_flags got=%b want=000", {flag_inv, flag_unf, flag_ovf}); else n_pass++;
      @(posedge clk); #1;
   endtask

   // Vectors 1..3 with a bubble between each, to show bubbles pass through untouched.
   task automatic test_arith();
      int   idx = 1, cyc = 0;
      exp_t e;
      out_ready = 1'b1;
      while ((idx < 4 || sbq.size() != 0) && cyc < 40) begin
         in_valid = (idx < 4) && (cyc % 2 == 0);
         if (idx < 4) begin a = va[idx]; b = vb[idx]; end
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_chk++;
            if (sbq.size() == 0) $display("FAIL arith_extra got=%h want=none", product);
            else begin
               e = sbq.pop_front();
               if ({product, flag_inv, flag_unf, flag_ovf} !== {e.p, e.f})
                  $display("FAIL arith got=%h/%b want=%h/%b", product, {flag_inv, flag_unf, flag_ovf}, e.p, e.f);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin sbq.push_back({vp[idx], vf[idx]}); idx++; end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_chk++; if (idx != 4 || sbq.size() != 0) $display("FAIL arith_drain got=%0d/%0d want=4/0", idx, sbq.size()); else n_pass++;
   endtask

   task automatic test_specials();
      int   idx = 4, cyc = 0;
      exp_t e;
      out_ready = 1'b1;
      while ((idx < 11 || sbq.size() != 0) && cyc < 40) begin
         in_valid = (idx < 11);
         if (idx < 11) begin a = va[idx]; b = vb[idx]; end
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_chk++;
            if (sbq.size() == 0) $display("FAIL special_extra got=%h want=none", product);
            else begin
               e = sbq.pop_front();
               if ({product, flag_inv, flag_unf, flag_ovf} !== {e.p, e.f})
                  $display("FAIL special got=%h/%b want=%h/%b", product, {flag_inv, flag_unf, flag_ovf}, e.p, e.f);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin sbq.push_back({vp[idx], vf[idx]}); idx++; end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_chk++; if (idx != 11 || sbq.size() != 0) $display("FAIL special_drain got=%0d/%0d want=11/0", idx, sbq.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int          idx = 11, cyc = 0, got = 0;
      logic        prev_stall = 1'b0;
      logic [34:0] prev_out = '0;
      exp_t        e;
      while ((idx < 16 || sbq.size() != 0) && cyc < 60) begin
         out_ready = !(cyc >= 4 && cyc <= 7);
         in_valid  = (idx < 16);
         if (idx < 16) begin a = va[idx]; b = vb[idx]; end
         @(negedge clk);
         if (prev_stall) begin
            n_chk++;
            if ({product, flag_inv, flag_unf, flag_ovf} !== prev_out)
               $display("FAIL bp_hold got=%h want=%h", {product, flag_inv, flag_unf, flag_ovf}, prev_out);
            else n_pass++;
         end
         if (out_valid && !out_ready) begin
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready); else n_pass++;
         end
         if (!out_valid) begin
            n_chk++; if ({flag_inv, flag_unf, flag_ovf} !== 3'b000)
               $display("FAIL bp_idle_flags got=%b want=000", {flag_inv, flag_unf, flag_ovf}); else n_pass++;
         end
         if (out_valid && out_ready) begin
            n_chk++;
            got++;
            if (sbq.size() == 0) $display("FAIL bp_extra got=%h want=none", product);
            else begin
               e = sbq.pop_front();
               if ({product, flag_inv, flag_unf, flag_ovf} !== {e.p, e.f})
                  $display("FAIL bp_order got=%h/%b want=%h/%b", product, {flag_inv, flag_unf, flag_ovf}, e.p, e.f);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin sbq.push_back({vp[idx], vf[idx]}); idx++; end
         prev_stall = out_valid && !out_ready;
         prev_out   = {product, flag_inv, flag_unf, flag_ovf};
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++; if (got != 5 || sbq.size() != 0) $display("FAIL bp_count got=%0d want=5", got); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 11; i < 14; i++) begin
         a = va[i]; b = vb[i]; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL mid_inflight got=%b want=1", out_valid); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b want=0", out_valid); else n_pass++;
      n_chk++; if (product !== 32'h0) $display("FAIL mid_product got=%h want=0", product); else n_pass++;
      n_chk++; if ({flag_inv, flag_unf, flag_ovf} !== 3'b000)
         $display("FAIL mid_flags got=%b want=000", {flag_inv, flag_unf, flag_ovf}); else n_pass++;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_chk++; if (seen != 0) $display("FAIL mid_stale got=%0d want=0", seen); else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      init_vectors();
      test_reset();
      test_latency();
      test_arith();
      test_specials();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
